// File: rtl/bit_scan_pkg.sv
// Shared types for bit_scan_encoder: scan state enum and the index-width helper.
package bit_scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        ZERO
    } state_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bit_scan_encoder_prio_index.sv
// Combinational priority finder: index of the highest (MSB_FIRST=1) or lowest set bit,
// plus found (any bit set) and onehot (exactly one bit set) flags.
module prio_index
    import bit_scan_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter int unsigned W         = idx_width(N),
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         found,
    output logic         onehot
);

    // Later loop iterations overwrite earlier ones, so the loop direction sets priority.
    always_comb begin
        idx = '0;
        if (MSB_FIRST) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (vec[i]) idx = W'(i);
            end
        end else begin
            for (int unsigned i = N; i > 0; i--) begin
                if (vec[i-1]) idx = W'(i - 1);
            end
        end
    end

    assign found  = |vec;
    assign onehot = found && ((vec & (vec - 1'b1)) == '0);

endmodule

// File: rtl/bit_scan_encoder.sv
// Registered bit-scan encoder: captures a request vector and emits the index of each set bit,
// one beat per handshake, in priority order. Define SCAN_COUNT_EN to add the out_count port.
module bit_scan_encoder
    import bit_scan_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N-1:0]             in_vec,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [idx_width(N)-1:0]  out_idx,
    output logic                     out_last,
    output logic                     out_zero
`ifdef SCAN_COUNT_EN
    ,
    output logic [idx_width(N):0]    out_count
`endif
);

    localparam int unsigned W = idx_width(N);

    state_t         state, state_n;
    logic [N-1:0]   pending, pending_n;
    logic [W-1:0]   p_idx;
    logic           p_found;
    logic           p_onehot;

    prio_index #(
        .N         (N),
        .W         (W),
        .MSB_FIRST (MSB_FIRST)
    ) u_prio (
        .vec    (pending),
        .idx    (p_idx),
        .found  (p_found),
        .onehot (p_onehot)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
        end else begin
            state   <= state_n;
            pending <= pending_n;
        end
    end

    always_comb begin
        state_n   = state;
        pending_n = pending;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_idx   = '0;
        out_last  = 1'b0;
        out_zero  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    pending_n = in_vec;
                    state_n   = (in_vec == '0) ? ZERO : SCAN;
                end
            end
            SCAN: begin
                // pending is never empty here; found doubles as the valid flag
                out_valid = p_found;
                out_idx   = p_idx;
                out_last  = p_onehot;
                if (out_ready) begin
                    pending_n[p_idx] = 1'b0;
                    if (p_onehot) state_n = IDLE;
                end
            end
            ZERO: begin
                out_valid = 1'b1;
                out_zero  = 1'b1;
                out_last  = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef SCAN_COUNT_EN
    logic [W:0] count;
    logic [W:0] count_in;

    always_comb begin
        count_in = '0;
        for (int unsigned i = 0; i < N; i++) begin
            count_in = count_in + (W+1)'(in_vec[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (state == IDLE && in_valid) begin
            count <= count_in;
        end else if (state != IDLE && state_n == IDLE) begin
            count <= '0;
        end
    end

    assign out_count = count;
`endif

endmodule

// File: tb/tb_bit_scan_encoder.sv
// Scoreboard bench for bit_scan_encoder: two instances (MSB-first and LSB-first) share stimulus.
module tb_bit_scan_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_vec;
    logic       out_ready;

    logic       m_in_ready, m_out_valid, m_out_last, m_out_zero;
    logic [2:0] m_out_idx;
    logic       l_in_ready, l_out_valid, l_out_last, l_out_zero;
    logic [2:0] l_out_idx;
`ifdef SCAN_COUNT_EN
    logic [3:0] m_out_count, l_out_count;
`endif

    int checks   = 0;
    int failures = 0;
    int mode     = 0;

    typedef struct {
        logic [2:0] idx;
        logic       last;
        logic       zero;
        logic [3:0] count;
    } beat_t;

    beat_t qm[$];
    beat_t ql[$];

    always #5 clk = ~clk;

    bit_scan_encoder #(.N(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready), .in_vec(in_vec),
        .out_valid(m_out_valid), .out_ready(out_ready), .out_idx(m_out_idx),
        .out_last(m_out_last), .out_zero(m_out_zero)
`ifdef SCAN_COUNT_EN
        , .out_count(m_out_count)
`endif
    );

    bit_scan_encoder #(.N(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(l_in_ready), .in_vec(in_vec),
        .out_valid(l_out_valid), .out_ready(out_ready), .out_idx(l_out_idx),
        .out_last(l_out_last), .out_zero(l_out_zero)
`ifdef SCAN_COUNT_EN
        , .out_count(l_out_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: list the set bits in priority order; the last listed is the final beat.
    task automatic push_expect(input logic [7:0] v);
        beat_t e;
        int    cnt;
        int    k;
        cnt = $countones(v);
        if (v == 8'h00) begin
            e = '{idx: 3'd0, last: 1'b1, zero: 1'b1, count: 4'd0};
            qm.push_back(e);
            ql.push_back(e);
        end else begin
            k = 0;
            for (int i = 7; i >= 0; i--) begin
                if (v[i]) begin
                    k++;
                    e = '{idx: 3'(i), last: (k == cnt), zero: 1'b0, count: 4'(cnt)};
                    qm.push_back(e);
                end
            end
            k = 0;
            for (int i = 0; i < 8; i++) begin
                if (v[i]) begin
                    k++;
                    e = '{idx: 3'(i), last: (k == cnt), zero: 1'b0, count: 4'(cnt)};
                    ql.push_back(e);
                end
            end
        end
    endtask

    // Every valid cycle is compared with the queue head; it is popped only on acceptance,
    // so stalled beats must stay equal to the same expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && m_out_valid === 1'b1) begin
            if (qm.size() == 0) begin
                check("msb_spurious_beat", 1, 0);
            end else begin
                check("msb_beat", {m_out_idx, m_out_last, m_out_zero},
                      {qm[0].idx, qm[0].last, qm[0].zero});
`ifdef SCAN_COUNT_EN
                check("msb_count", m_out_count, qm[0].count);
`endif
                if (out_ready) void'(qm.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && l_out_valid === 1'b1) begin
            if (ql.size() == 0) begin
                check("lsb_spurious_beat", 1, 0);
            end else begin
                check("lsb_beat", {l_out_idx, l_out_last, l_out_zero},
                      {ql[0].idx, ql[0].last, ql[0].zero});
`ifdef SCAN_COUNT_EN
                check("lsb_count", l_out_count, ql[0].count);
`endif
                if (out_ready) void'(ql.pop_front());
            end
        end
    end

    // out_ready pattern: 0 = always, 1 = toggling, 2 = random
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                1:       out_ready = ~out_ready;
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
        end
    end

    task automatic send(input logic [7:0] v);
        int n;
        in_vec   = v;
        in_valid = 1'b1;
        n = 0;
        while (m_in_ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("send_ready_timeout", 32'(m_in_ready === 1'b1), 1);
        @(posedge clk);
        #1;
        push_expect(v);
        in_valid = 1'b0;
        in_vec   = $urandom;
    endtask

    task automatic drain_and_check_ready(input string name);
        int n;
        n = 0;
        while ((qm.size() != 0 || ql.size() != 0) && n < 500) begin
            @(posedge clk);
            n++;
        end
        check({name, "_drain"}, qm.size() + ql.size(), 0);
        @(negedge clk);
        check({name, "_ready"}, {m_in_ready, l_in_ready, m_out_valid, l_out_valid}, 4'b1100);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_vec   = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {m_in_ready, l_in_ready, m_out_valid, l_out_valid}, 4'b1100);
        check("reset_idx", {m_out_idx, m_out_last, m_out_zero, l_out_idx, l_out_last, l_out_zero}, 0);
`ifdef SCAN_COUNT_EN
        check("reset_count", {m_out_count, l_out_count}, 0);
`endif
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_reset_idle", {m_out_valid, l_out_valid, m_in_ready, l_in_ready}, 4'b0011);
        end

        mode = 0;
        @(posedge clk);
        #1;
        for (int i = 7; i >= 0; i--) begin
            send(8'(1 << i));
        end
        drain_and_check_ready("onehot");

        send(8'b1010_0110);
        drain_and_check_ready("multi_cont");

        mode = 1;
        send(8'b1010_0110);
        drain_and_check_ready("multi_toggle");

        mode = 0;
        send(8'h00);
        drain_and_check_ready("zero");

        send(8'hFF);
        drain_and_check_ready("all_ones");

        mode = 2;
        repeat (40) begin
            logic [7:0] v;
            v = 8'($urandom);
            if ($urandom_range(0, 7) == 0) v = 8'h00;
            send(v);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        drain_and_check_ready("random");

        // Reset after the second accepted beat of 8'hFF
        mode = 0;
        @(posedge clk);
        #1;
        send(8'hFF);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("midscan_left", qm.size() + ql.size(), 12);
`ifdef SCAN_COUNT_EN
        check("midscan_count_before", {m_out_count, l_out_count}, 8'h88);
`endif
        rst_n = 1'b0;
        qm.delete();
        ql.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("midscan_idle", {m_out_valid, l_out_valid, m_in_ready, l_in_ready}, 4'b0011);
`ifdef SCAN_COUNT_EN
            check("midscan_count_after", {m_out_count, l_out_count}, 0);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
